// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-channel TDM demultiplexer.
// Imported by the demux top and its slot counter.
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer. It tracks which slot the next valid beat
// should carry. It only counts: the demux top decides when to load, clear or advance it.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_one,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  // Clear wins over load, and load wins over increment. The increment wraps 3 -> 0 by width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link. It rebuilds four parallel channels from slot-ordered beats.
// It publishes only complete frames and flags sync errors with a pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [WIDTH-1:0]  q0,
  output logic [WIDTH-1:0]  q1,
  output logic [WIDTH-1:0]  q2,
  output logic [WIDTH-1:0]  q3,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err
);

  state_t state, state_next;

  logic [WIDTH-1:0] shadow [NCH-1];

  logic ctr_clear, ctr_load, ctr_inc;
  logic wr_sh0, wr_sh1, wr_sh2;
  logic frame_done, err_det;

  tdm_slot_ctr u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (ctr_clear),
    .load_one (ctr_load),
    .inc      (ctr_inc),
    .slot     (slot)
  );

  // Framing decisions. Idle cycles leave every default in place, so nothing moves.
  always_comb begin
    state_next = state;
    ctr_clear  = 1'b0;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    wr_sh0     = 1'b0;
    wr_sh1     = 1'b0;
    wr_sh2     = 1'b0;
    frame_done = 1'b0;
    err_det    = 1'b0;
    if (din_valid) begin
      unique case (state)
        ST_HUNT: begin
          if (sync) begin
            wr_sh0     = 1'b1;
            ctr_load   = 1'b1;
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (sync) begin
            // A sync beat always starts a new frame. A sync beat that arrives early also drops the partial frame.
            wr_sh0   = 1'b1;
            ctr_load = 1'b1;
            err_det  = (slot != SLOT_W'(0));
          end else begin
            case (slot)
              2'd0: begin
                err_det    = 1'b1;
                ctr_clear  = 1'b1;
                state_next = ST_HUNT;
              end
              2'd1: begin
                wr_sh1  = 1'b1;
                ctr_inc = 1'b1;
              end
              2'd2: begin
                wr_sh2  = 1'b1;
                ctr_inc = 1'b1;
              end
              2'd3: begin
                frame_done = 1'b1;
                ctr_clear  = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow[0] <= '0;
      shadow[1] <= '0;
      shadow[2] <= '0;
    end else begin
      if (wr_sh0) shadow[0] <= din;
      if (wr_sh1) shadow[1] <= din;
      if (wr_sh2) shadow[2] <= din;
    end
  end

  // The slot-3 beat goes straight to q3, so the frame is published on the edge that completes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0          <= '0;
      q1          <= '0;
      q2          <= '0;
      q3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (frame_done) begin
        q0 <= shadow[0];
        q1 <= shadow[1];
        q2 <= shadow[2];
        q3 <= din;
      end
      frame_valid <= frame_done;
      sync_err    <= err_det;
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4. A frame-level model predicts every cycle,
// and literal checks at key points pin the model itself.
module tb_tdm_demux4;

  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] q0, q1, q2, q3;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             sync_err;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Frame-level model: aligned flag, the number of beats collected so far, and the published frame.
  bit               m_aligned;
  int               m_count;
  logic [WIDTH-1:0] m_buf [4];
  logic [WIDTH-1:0] exp_q [4];
  logic             exp_fv;
  logic             exp_err;
  logic [1:0]       exp_slot;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_aligned = 1'b0;
    m_count   = 0;
    for (int i = 0; i < 4; i++) begin
      m_buf[i] = '0;
      exp_q[i] = '0;
    end
    exp_fv   = 1'b0;
    exp_err  = 1'b0;
    exp_slot = 2'd0;
  endtask

  task automatic modelBeat(input logic v, input logic s, input logic [WIDTH-1:0] d);
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    if (v) begin
      if (s) begin
        if (m_aligned && m_count != 0) exp_err = 1'b1;
        m_aligned = 1'b1;
        m_buf[0]  = d;
        m_count   = 1;
      end else if (m_aligned) begin
        if (m_count == 0) begin
          exp_err   = 1'b1;
          m_aligned = 1'b0;
        end else begin
          m_buf[m_count] = d;
          m_count++;
          if (m_count == 4) begin
            exp_q   = m_buf;
            exp_fv  = 1'b1;
            m_count = 0;
          end
        end
      end
    end
    exp_slot = 2'(m_count);
  endtask

  task automatic checkOutput();
    cmp("q0", 8'(q0), 8'(exp_q[0]));
    cmp("q1", 8'(q1), 8'(exp_q[1]));
    cmp("q2", 8'(q2), 8'(exp_q[2]));
    cmp("q3", 8'(q3), 8'(exp_q[3]));
    cmp("frame_valid", 8'(frame_valid), 8'(exp_fv));
    cmp("sync_err", 8'(sync_err), 8'(exp_err));
    cmp("slot", 8'(slot), 8'(exp_slot));
    cmp("pulse_excl", 8'(frame_valid & sync_err), 8'd0);
  endtask

  task automatic checkLit(input string name, input int e0, input int e1, input int e2,
                          input int e3, input int efv, input int eerr, input int eslot);
    cmp({name, ".q0"}, 8'(q0), 8'(e0));
    cmp({name, ".q1"}, 8'(q1), 8'(e1));
    cmp({name, ".q2"}, 8'(q2), 8'(e2));
    cmp({name, ".q3"}, 8'(q3), 8'(e3));
    cmp({name, ".fv"}, 8'(frame_valid), 8'(efv));
    cmp({name, ".err"}, 8'(sync_err), 8'(eerr));
    cmp({name, ".slot"}, 8'(slot), 8'(eslot));
  endtask

  // Each call presents one cycle of input and returns after the compare process has sampled.
  task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = d;
    modelBeat(v, s, d);
    @(posedge clk);
    #2;
  endtask

  task automatic sendFrame(input int a, input int b, input int c, input int e, input bit gaps);
    applyStimulus(1'b1, 1'b1, 2'(a));
    if (gaps) applyStimulus(1'b0, 1'b0, 2'(3));
    applyStimulus(1'b1, 1'b0, 2'(b));
    if (gaps) applyStimulus(1'b0, 1'b1, 2'(0));
    applyStimulus(1'b1, 1'b0, 2'(c));
    if (gaps) applyStimulus(1'b0, 1'b0, 2'(1));
    applyStimulus(1'b1, 1'b0, 2'(e));
  endtask

  always @(posedge clk) begin
    #1;
    if (check_en) checkOutput();
  end

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;
    modelReset();
    check_en  = 1'b1;
    #3;
    checkLit("reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    $display("[TB] test 1: back-to-back frame");
    sendFrame(0, 1, 2, 3, 1'b0);
    checkLit("t1", 0, 1, 2, 3, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkLit("t1_after", 0, 1, 2, 3, 0, 0, 0);

    $display("[TB] test 2: frame with idle gaps");
    applyStimulus(1'b1, 1'b1, 2'd0);
    applyStimulus(1'b0, 1'b0, 2'd3);
    applyStimulus(1'b1, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b1, 2'd1);
    checkLit("t2_gap", 0, 1, 2, 3, 0, 0, 3);
    applyStimulus(1'b1, 1'b0, 2'd3);
    checkLit("t2", 0, 1, 2, 3, 1, 0, 0);

    $display("[TB] test 3: unaligned beats after reset");
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd2);
    applyStimulus(1'b1, 1'b0, 2'd3);
    checkLit("t3_hunt", 0, 0, 0, 0, 0, 0, 0);
    sendFrame(3, 2, 1, 0, 1'b0);
    checkLit("t3", 3, 2, 1, 0, 1, 0, 0);

    $display("[TB] test 4: early sync");
    sendFrame(0, 1, 2, 3, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1);
    applyStimulus(1'b1, 1'b0, 2'd2);
    applyStimulus(1'b1, 1'b1, 2'd3);
    checkLit("t4_err", 0, 1, 2, 3, 0, 1, 1);
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd1);
    applyStimulus(1'b1, 1'b0, 2'd2);
    checkLit("t4", 3, 0, 1, 2, 1, 0, 0);

    $display("[TB] test 5: missing sync");
    sendFrame(2, 3, 0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0);
    checkLit("t5_err", 2, 3, 0, 1, 0, 1, 0);
    applyStimulus(1'b1, 1'b0, 2'd3);
    checkLit("t5_hunt", 2, 3, 0, 1, 0, 0, 0);
    sendFrame(1, 1, 2, 2, 1'b1);
    checkLit("t5", 1, 1, 2, 2, 1, 0, 0);

    $display("[TB] test 6: reset mid-frame");
    applyStimulus(1'b1, 1'b1, 2'd3);
    applyStimulus(1'b1, 1'b0, 2'd3);
    @(negedge clk);
    din_valid = 1'b1;
    sync      = 1'b0;
    din       = 2'd3;
    rst       = 1'b1;
    modelReset();
    #1;
    checkLit("t6_rst", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 2'd3);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    sendFrame(3, 0, 3, 0, 1'b0);
    checkLit("t6", 3, 0, 3, 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 2'd0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
